// File: rtl/dfe_output_requant_pkg.sv
// Shared constants and helpers for the DFE output requantiser.
package dfe_out_pkg;

  localparam int IN_W      = 28;
  localparam int OUT_W     = 16;
  localparam int FRAC_W    = 15;
  localparam int MAX_SHIFT = 12;
  localparam int SUM_W     = IN_W + 1;

  localparam logic signed [OUT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] SAT_MIN = 16'sh8000;

  typedef logic [3:0] shift_t;

  function automatic shift_t clamp_shift(input logic [3:0] sel);
    return (sel > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : sel;
  endfunction

endpackage

// File: rtl/dfe_output_requant_if.sv
// Output stream of the requantiser: show-ahead data with valid/ready handshake.
interface dfe_output_requant_if;
  import dfe_out_pkg::*;

  logic signed [OUT_W-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/dfe_output_requant_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered show-ahead head word.
module dfe_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW-1:0]    level, levelAfterRd;
  logic             wrFire, rdFire;
  logic [WIDTH-1:0] head_q, head_d;

  assign empty_o      = (wrPtr_q == rdPtr_q);
  assign full_o       = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign rdFire       = rd_en_i && !empty_o;
  assign wrFire       = wr_en_i && (!full_o || rdFire);
  assign level        = wrPtr_q - rdPtr_q;
  assign levelAfterRd = level - PW'(rdFire);
  assign wrPtr_d      = wrPtr_q + PW'(wrFire);
  assign rdPtr_d      = rdPtr_q + PW'(rdFire);
  assign level_o      = level;
  assign rd_data_o    = head_q;

  // Head tracks the oldest word after this edge; a write into a drained FIFO bypasses storage.
  always_comb begin
    head_d = head_q;
    if (wrPtr_d != rdPtr_d) begin
      if (levelAfterRd == '0) head_d = wr_data_i;
      else                    head_d = mem_q[rdPtr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wrFire) mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      head_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/dfe_output_requant.sv
// Round/shift/saturate s28.15 filter output to Q1.15 and buffer it in a FIFO.
// Define DFE_REQUANT_STATS_EN to build the saturation and drop event counters.
module dfe_output_requant
  import dfe_out_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic signed [IN_W-1:0]   y_in,
  input  logic                     y_in_valid,
  input  logic [3:0]               shift_sel,
  dfe_output_requant_if.master     m_if,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     status_sat,
  output logic                     status_overflow,
  output logic [15:0]              sat_count,
  output logic [15:0]              drop_count
);

  localparam logic signed [SUM_W-1:0] HI_LIM = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] LO_LIM = SUM_W'(SAT_MIN);

  shift_t                  shiftClamped;
  logic signed [SUM_W-1:0] roundBias, s1Sum_d, s1Sum_q, shifted;
  shift_t                  s1Shift_q;
  logic                    s1Valid_q, s2Valid_q;
  logic                    satHi, satLo, satEvent;
  logic signed [OUT_W-1:0] s2Data_d, s2Data_q;
  logic                    fifoWrReq, fifoRd, fifoFull, fifoEmpty, dropEvent;
  logic [OUT_W-1:0]        fifoHead;

  assign shiftClamped = clamp_shift(shift_sel);
  assign roundBias    = (shiftClamped == '0) ? '0 : (SUM_W'(1) << (shiftClamped - 4'd1));
  assign s1Sum_d      = {y_in[IN_W-1], y_in} + roundBias;

  assign shifted  = s1Sum_q >>> s1Shift_q;
  assign satHi    = shifted > HI_LIM;
  assign satLo    = shifted < LO_LIM;
  assign s2Data_d = satHi ? SAT_MAX : (satLo ? SAT_MIN : shifted[OUT_W-1:0]);
  assign satEvent = clk_enable && s1Valid_q && (satHi || satLo);

  // Whole input path freezes with clk_enable; valid bits hold so a held sample resumes later.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid_q <= 1'b0;
      s1Sum_q   <= '0;
      s1Shift_q <= '0;
      s2Valid_q <= 1'b0;
      s2Data_q  <= '0;
    end else if (clk_enable) begin
      s1Valid_q <= y_in_valid;
      if (y_in_valid) begin
        s1Sum_q   <= s1Sum_d;
        s1Shift_q <= shiftClamped;
      end
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) s2Data_q <= s2Data_d;
    end
  end

  assign fifoWrReq = clk_enable && s2Valid_q;
  assign fifoRd    = !fifoEmpty && m_if.m_ready;
  assign dropEvent = fifoWrReq && fifoFull && !fifoRd;

  dfe_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifoWrReq),
    .wr_data_i (s2Data_q),
    .rd_en_i   (m_if.m_ready),
    .rd_data_o (fifoHead),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .level_o   (fifo_level)
  );

  assign m_if.m_data  = fifoHead;
  assign m_if.m_valid = !fifoEmpty;

  always_ff @(posedge clk) begin
    if (reset) begin
      status_sat      <= 1'b0;
      status_overflow <= 1'b0;
    end else begin
      if (satEvent)  status_sat      <= 1'b1;
      if (dropEvent) status_overflow <= 1'b1;
    end
  end

`ifdef DFE_REQUANT_STATS_EN
  logic [15:0] satCount_q, dropCount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      satCount_q  <= '0;
      dropCount_q <= '0;
    end else begin
      if (satEvent && satCount_q != 16'hFFFF)   satCount_q  <= satCount_q + 16'd1;
      if (dropEvent && dropCount_q != 16'hFFFF) dropCount_q <= dropCount_q + 16'd1;
    end
  end

  assign sat_count  = satCount_q;
  assign drop_count = dropCount_q;
`else
  assign sat_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: doc/dfe_output_requant.md
# dfe_output_requant

Downstream neighbour of the CIC/compensation third stage in the DFE chain. Consumes the stage's decimated 28-bit s28.15 output (`y_out`/`y_valid`) and applies a per-sample programmable right shift with round-half-up and saturation to 16-bit Q1.15. Results are buffered in a small FIFO behind a valid/ready handshake, so a stalling consumer never back-pressures the non-stallable filter. Overflow and drop conditions are reported as status flags.

## Interface
- `DEPTH`, 8, FIFO depth in words; power of two, ≥ 4
- `clk`  in  1  single clock; every register is updated on its rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `clk_enable`  in  1  input-path enable; when low, the input pipeline holds and accepts nothing
- `y_in`  in  28  signed s28.15 sample; connects to the CIC stage `y_out`
- `y_in_valid`  in  1  sample strobe; connects to the CIC stage `y_valid`
- `shift_sel`  in  4  right-shift amount 0..12; values 13..15 clamp to 12
- `m_ready`  in  1  consumer ready
- `m_data`  out  16  signed Q1.15 FIFO head (show-ahead)
- `m_valid`  out  1  FIFO not empty
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy
- `status_sat`  out  1  sticky; set on any saturation
- `status_overflow`  out  1  sticky; set on any dropped sample
- `sat_count`  out  16  saturation event count (see Configuration)
- `drop_count`  out  16  dropped-sample count (see Configuration)

## Operation
- Sample acceptance: a sample is accepted when `clk_enable && y_in_valid` at a rising edge.
- S1 (round): `shift_sel` is clamped and captured with the sample, so each sample is shifted by the value present when it was accepted.
  - Compute a 29-bit sum = `y_in` + (shift>0 ? 1<<(shift−1) : 0).
- S2 (shift + saturate):
  - Arithmetic right shift by the captured shift.
  - Result > 32767 → 32767; result < −32768 → −32768.
  - Either clamp sets `status_sat` and increments `sat_count`.
- FIFO write: S2's valid output writes the FIFO.
  - If the FIFO is full and no read occurs in the same cycle, the sample is dropped: `status_overflow` is set and `drop_count` increments. The FIFO contents are unchanged.
  - A write and a read in the same cycle when full both succeed; the level is unchanged.
- FIFO read: a word transfers when `m_valid && m_ready`.
  - The read side is never gated by `clk_enable`.
  - When the FIFO is empty, `m_data` holds its last value; the output is don't-care and the bench must not check it.
- Counters:
  - Both counters saturate at 16'hFFFF and never wrap.
  - Sticky flags clear only on `reset`.
- No state machine beyond pipeline valid bits and the FIFO pointers. Pointers are `$clog2(DEPTH)+1` bits wide, with wrap-bit full/empty detection.

## Timing
- Latency: a sample accepted at edge k is written to the FIFO at edge k+2 and is visible on `m_data`/`m_valid` after edge k+2. This gives 3-register latency when the FIFO is empty.
- Throughput: one sample per cycle in, one word per cycle out.
- `clk_enable` low: the S1/S2 registers hold their contents and valid bits. No FIFO write occurs from a held stage.
- Reset values: `m_valid`=0, `m_data`=0, `fifo_level`=0, `status_sat`=0, `status_overflow`=0, `sat_count`=0, `drop_count`=0, pipeline valids=0.
- Reset mid-operation: all data in flight and in the FIFO is discarded. Outputs show reset values after the edge where `reset` is sampled high. `reset` has priority over `clk_enable` and all other inputs.
- `m_data` is registered from FIFO storage; there is no combinational path from `y_in` to any output.

## Configuration
- Macro: `DFE_REQUANT_STATS_EN`.
  - Defined: `sat_count` and `drop_count` are implemented as described.
  - Undefined: the counters are not synthesized and both ports drive constant 0.
- The sticky flags are present in both builds.

## Structure
- Package `dfe_out_pkg` holds the shared constants:
  - `IN_W`=28, `OUT_W`=16, `FRAC_W`=15, `MAX_SHIFT`=12
  - `SAT_MAX`=16'sh7FFF, `SAT_MIN`=16'sh8000
- Sub-module `dfe_sync_fifo` (params `WIDTH`, `DEPTH`): provides write/read ports, `full`, `empty`, `level`, and a show-ahead registered head.
- Top level contains the S1/S2 pipeline, drop logic, flags and the conditional counters.

## Test plan
- `shift_sel`=0, `y_in`=1000, `m_ready`=1 → `m_data`=1000 with `m_valid` high after 3 edges; `fifo_level` returns to 0.
- `shift_sel`=4, `y_in`=24 then −24 → `m_data`=2 then −1 (round half up); `status_sat`=0.
- `shift_sel`=0, `y_in`=40000 then −40000 → `m_data`=32767 then −32768; `status_sat`=1; `sat_count`=2 with the macro, 0 without.
- `m_ready`=0, `DEPTH`=8, 10 consecutive samples 1..10 → `fifo_level`=8, `status_overflow`=1, `drop_count`=2. Then `m_ready`=1 → 1..8 read out in order, one per cycle.
- `clk_enable`=0 with `y_in_valid`=1 for 5 cycles → no writes and `fifo_level` unchanged. Raising `clk_enable` mid-pipeline completes the held sample.
- With `fifo_level`=5 and counters nonzero, assert `reset` for 1 cycle → `m_valid`=0, `fifo_level`=0, flags and counters 0. The next sample appears 3 edges after acceptance.
